// File: rtl/varredura_pkg.sv
// Shared definitions for the sonar sweep control unit:
// state codes, position width and counter width helper.
package varredura_pkg;

   localparam int POSICAO_W = 3;

   typedef enum logic [3:0] {
      INICIAL       = 4'd0,
      PREPARA       = 4'd1,
      ESPERA_SERVO  = 4'd2,
      ACIONA_MEDIDA = 4'd3,
      AGUARDA_TRENA = 4'd4,
      PROXIMA       = 4'd5
   } estado_t;

   function automatic int largura_contador(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/contador_espera.sv
// Up-counter with synchronous clear/enable and terminal-count flag.
// Ports: clock, reset (async), limpar_i, conta_i, limite_i -> fim_o.
module contador_espera #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         limpar_i,
   input  logic         conta_i,
   input  logic [W-1:0] limite_i,
   output logic         fim_o
);

   logic [W-1:0] valor_q, valor_d;

   always_comb begin
      valor_d = valor_q;
      if (limpar_i)
         valor_d = '0;
      else if (conta_i)
         valor_d = valor_q + W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         valor_q <= '0;
      else
         valor_q <= valor_d;
   end

   assign fim_o = (valor_q == limite_i);

endmodule

// File: rtl/controle_varredura_uc.sv
// Sonar sweep control unit: ping-pong servo stepping, settle dwell,
// one trena cycle per position. Ports: clock, reset, ligar,
// trena_pronto -> mensurar, posicao, varrendo, meia_volta,
// erro_timeout, db_estado. Optional: VARREDURA_TIMEOUT_EN.
module controle_varredura_uc
   import varredura_pkg::*;
#(
   parameter int N_POSICOES     = 8,
   parameter int CICLOS_ESPERA  = 25_000_000,
   parameter int TIMEOUT_CICLOS = 50_000_000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 ligar,
   input  logic                 trena_pronto,
   output logic                 mensurar,
   output logic [POSICAO_W-1:0] posicao,
   output logic                 varrendo,
   output logic                 meia_volta,
   output logic                 erro_timeout,
   output logic [3:0]           db_estado
);

   localparam int CW = largura_contador(CICLOS_ESPERA, TIMEOUT_CICLOS);
   localparam logic [CW-1:0] LIM_ESPERA = CW'(CICLOS_ESPERA - 1);
   localparam logic [POSICAO_W-1:0] ULTIMA = POSICAO_W'(N_POSICOES - 1);

   estado_t              state_q, state_d;
   logic [POSICAO_W-1:0] pos_q, pos_d;
   logic                 sobe_q, sobe_d;
   logic                 meia;
   logic                 cnt_clr, cnt_en, cnt_fim;
   logic [CW-1:0]        limite;

`ifdef VARREDURA_TIMEOUT_EN
   localparam logic [CW-1:0] LIM_TO = CW'(TIMEOUT_CICLOS - 1);
   logic err_q, err_d;
   // One counter serves both waits; the limit follows the state.
   assign limite = (state_q == AGUARDA_TRENA) ? LIM_TO : LIM_ESPERA;
`else
   assign limite = LIM_ESPERA;
`endif

   contador_espera #(.W(CW)) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .limpar_i(cnt_clr),
      .conta_i (cnt_en),
      .limite_i(limite),
      .fim_o   (cnt_fim)
   );

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      sobe_d  = sobe_q;
      meia    = 1'b0;
      cnt_clr = 1'b1;
      cnt_en  = 1'b0;
`ifdef VARREDURA_TIMEOUT_EN
      err_d   = err_q;
`endif
      unique case (state_q)
         INICIAL: begin
            if (ligar)
               state_d = PREPARA;
         end
         PREPARA: begin
            pos_d   = '0;
            sobe_d  = 1'b1;
`ifdef VARREDURA_TIMEOUT_EN
            err_d   = 1'b0;
`endif
            state_d = ESPERA_SERVO;
         end
         ESPERA_SERVO: begin
            if (!ligar)
               state_d = INICIAL;
            else if (cnt_fim)
               state_d = ACIONA_MEDIDA;
            else begin
               cnt_clr = 1'b0;
               cnt_en  = 1'b1;
            end
         end
         ACIONA_MEDIDA: begin
            state_d = AGUARDA_TRENA;
         end
         AGUARDA_TRENA: begin
            if (trena_pronto)
               state_d = ligar ? PROXIMA : INICIAL;
`ifdef VARREDURA_TIMEOUT_EN
            else if (cnt_fim) begin
               err_d   = 1'b1;
               state_d = ligar ? PROXIMA : INICIAL;
            end else begin
               cnt_clr = 1'b0;
               cnt_en  = 1'b1;
            end
`endif
         end
         PROXIMA: begin
            if (sobe_q) begin
               if (pos_q < ULTIMA)
                  pos_d = pos_q + 3'd1;
               else begin
                  sobe_d = 1'b0;
                  pos_d  = ULTIMA - 3'd1;
                  meia   = 1'b1;
               end
            end else begin
               if (pos_q != '0)
                  pos_d = pos_q - 3'd1;
               else begin
                  sobe_d = 1'b1;
                  pos_d  = 3'd1;
                  meia   = 1'b1;
               end
            end
            state_d = ligar ? ESPERA_SERVO : INICIAL;
         end
         default: state_d = INICIAL;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= INICIAL;
         pos_q   <= '0;
         sobe_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         sobe_q  <= sobe_d;
      end
   end

`ifdef VARREDURA_TIMEOUT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   end
   assign erro_timeout = err_q;
`else
   assign erro_timeout = 1'b0;
`endif

   always_comb begin
      db_estado = 4'hF;
      unique case (state_q)
         INICIAL, PREPARA, ESPERA_SERVO,
         ACIONA_MEDIDA, AGUARDA_TRENA, PROXIMA:
            db_estado = state_q;
         default: db_estado = 4'hF;
      endcase
   end

   assign mensurar   = (state_q == ACIONA_MEDIDA);
   assign varrendo   = (state_q != INICIAL);
   assign meia_volta = meia;
   assign posicao    = pos_q;

endmodule

// File: tb/tb_controle_varredura_uc.sv
// Self-checking bench for controle_varredura_uc (N=4 and N=2 instances).
// Timeout checks run when VARREDURA_TIMEOUT_EN is defined.
module tb_controle_varredura_uc;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic lig1 = 1'b0, pr1 = 1'b0, lig2 = 1'b0, pr2 = 1'b0;
   logic mens1, var1, meia1, err1, mens2, var2, meia2, err2;
   logic [2:0] pos1, pos2;
   logic [3:0] db1, db2;
   bit sel = 1'b0;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   controle_varredura_uc #(
      .N_POSICOES(4), .CICLOS_ESPERA(4), .TIMEOUT_CICLOS(10)
   ) dut (
      .clock(clk), .reset(rst), .ligar(lig1), .trena_pronto(pr1),
      .mensurar(mens1), .posicao(pos1), .varrendo(var1),
      .meia_volta(meia1), .erro_timeout(err1), .db_estado(db1)
   );

   controle_varredura_uc #(
      .N_POSICOES(2), .CICLOS_ESPERA(4), .TIMEOUT_CICLOS(10)
   ) dut2 (
      .clock(clk), .reset(rst), .ligar(lig2), .trena_pronto(pr2),
      .mensurar(mens2), .posicao(pos2), .varrendo(var2),
      .meia_volta(meia2), .erro_timeout(err2), .db_estado(db2)
   );

   logic       m_mens, m_var, m_meia, m_err;
   logic [2:0] m_pos;
   logic [3:0] m_db;
   assign m_mens = sel ? mens2 : mens1;
   assign m_var  = sel ? var2  : var1;
   assign m_meia = sel ? meia2 : meia1;
   assign m_err  = sel ? err2  : err1;
   assign m_pos  = sel ? pos2  : pos1;
   assign m_db   = sel ? db2   : db1;

   // Reference: visit k of a ping-pong sweep over n positions.
   function automatic int ref_pos(input int k, input int n);
      int p, m;
      p = 2 * (n - 1);
      m = k % p;
      return (m < n) ? m : p - m;
   endfunction

   // Direction flips when leaving an end position, except the very
   // first visit at 0, which already heads upward.
   function automatic logic ref_meia(input int k, input int n);
      int p, m;
      p = 2 * (n - 1);
      m = k % p;
      return (m == n - 1) || (m == 0 && k > 0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic setpr(input logic b);
      if (sel) pr2 = b; else pr1 = b;
   endtask

   task automatic setlig(input logic b);
      if (sel) lig2 = b; else lig1 = b;
   endtask

   task automatic wait_mens(input bit spur, output int c);
      c = 0;
      while (c < 100 && !m_mens) begin
         setpr(spur ? logic'($urandom_range(0, 1)) : 1'b0);
         tick;
         c++;
      end
      setpr(1'b0);
      if (!m_mens) chk("mens_seen", {31'd0, m_mens}, 32'd1);
   endtask

   task automatic visit(input int k, input int n, input int d,
                        input bit drop);
      chk("pos", m_pos, ref_pos(k, n));
      chk("mens_on", m_mens, 1);
      tick;
      chk("mens_width", m_mens, 0);
      chk("db_aguarda", m_db, 4);
      if (drop) setlig(1'b0);
      repeat (d) tick;
      chk("db_hold", m_db, 4);
      setpr(1'b1);
      tick;
      setpr(1'b0);
      if (drop) begin
         chk("db_drop", m_db, 0);
         chk("pos_drop", m_pos, ref_pos(k, n));
         chk("var_drop", m_var, 0);
      end else begin
         chk("db_proxima", m_db, 5);
         chk("meia", m_meia, ref_meia(k, n));
         tick;
         chk("pos_next", m_pos, ref_pos(k + 1, n));
         chk("meia_off", m_meia, 0);
      end
   endtask

   initial begin
      int c, hits;
      repeat (3) tick;
      chk("rst_db", db1, 0);
      chk("rst_pos", pos1, 0);
      chk("rst_var", var1, 0);
      chk("rst_mens", mens1, 0);
      chk("rst_meia", meia1, 0);
      chk("rst_err", err1, 0);
      rst = 1'b0;
      tick;

      // Main sweep, N=4
      sel = 1'b0;
      setlig(1'b1);
      wait_mens(1'b0, c);
      chk("latency", c, 6);
      for (int k = 0; k < 7; k++) begin
         visit(k, 4, (k < 4) ? 3 : $urandom_range(1, 5), 1'b0);
         wait_mens(k >= 3, c);
         chk("dwell", c, 4);
      end
      // Visit 7 sits at position 1; drop ligar mid-measurement
      visit(7, 4, 2, 1'b1);
      hits = 0;
      repeat (10) begin
         tick;
         if (mens1) hits++;
      end
      chk("idle_mens", hits, 0);
      chk("idle_pos", pos1, 1);

      // Reset mid-sweep at position 2 in aguarda_trena
      setlig(1'b1);
      wait_mens(1'b0, c);
      chk("latency2", c, 6);
      for (int k = 0; k < 2; k++) begin
         visit(k, 4, $urandom_range(1, 5), 1'b0);
         wait_mens(1'b1, c);
         chk("dwell2", c, 4);
      end
      chk("pos_pre_rst", pos1, 2);
      tick;
      chk("db_pre_rst", db1, 4);
      #2 rst = 1'b1;
      #1;
      chk("arst_pos", pos1, 0);
      chk("arst_db", db1, 0);
      chk("arst_var", var1, 0);
      setlig(1'b0);
      tick;
      rst = 1'b0;
      hits = 0;
      repeat (10) begin
         tick;
         if (mens1) hits++;
      end
      chk("post_rst_mens", hits, 0);

      // N=2 instance
      sel = 1'b1;
      setlig(1'b1);
      wait_mens(1'b0, c);
      chk("latency_n2", c, 6);
      for (int k = 0; k < 5; k++) begin
         visit(k, 2, $urandom_range(1, 4), 1'b0);
         wait_mens(1'b1, c);
         chk("dwell_n2", c, 4);
      end
      setlig(1'b0);
      sel = 1'b0;

`ifdef VARREDURA_TIMEOUT_EN
      setlig(1'b1);
      wait_mens(1'b0, c);
      chk("to_pos0", pos1, 0);
      tick;
      c = 0;
      while (c < 40 && db1 != 4'd5) begin
         tick;
         c++;
      end
      chk("to_cycles", c, 10);
      chk("to_err", err1, 1);
      tick;
      chk("to_pos1", pos1, 1);
      chk("to_sticky", err1, 1);
      setlig(1'b0);
      tick;
      chk("to_inicial", db1, 0);
      chk("to_sticky2", err1, 1);
      setlig(1'b1);
      tick;
      chk("to_prepara", db1, 1);
      tick;
      chk("to_clear", err1, 0);
      wait_mens(1'b0, c);
      chk("to_pos_restart", pos1, 0);
      tick;
      repeat (9) tick;
      setpr(1'b1);
      tick;
      setpr(1'b0);
      chk("to_race_db", db1, 5);
      chk("to_race_err", err1, 0);
      setlig(1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
